// File: rtl/mips_muldiv_pkg.sv
// Shared types for the iterative HI/LO multiply/divide unit.
package mips_muldiv_pkg;

    // Operation select driven by the core's decoder.
    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } muldiv_op_t;

    // Sequencer states: wait for work, iterate, apply signs and commit.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

    // True for the four operations that run through the iterative datapath.
    function automatic logic is_arith_op(input muldiv_op_t o);
        return (o == MULT) || (o == MULTU) || (o == DIV) || (o == DIVU);
    endfunction

    // True for the operations that treat operands as two's complement.
    function automatic logic is_signed_op(input muldiv_op_t o);
        return (o == MULT) || (o == DIV);
    endfunction

    // True for the division operations.
    function automatic logic is_div_op(input muldiv_op_t o);
        return (o == DIV) || (o == DIVU);
    endfunction

endpackage

// File: rtl/mips_muldiv_unit_step.sv
// One radix-2 step of the magnitude datapath, purely combinational.
// Multiply: {rem,quo} is the running product, quo shifting the multiplier
// out at the bottom while the partial sum grows into rem.
// Divide: {rem,quo} shifts left; quo carries the dividend in and collects
// quotient bits, rem holds the partial remainder (restoring algorithm).
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic           fits;

    // Select between a shift-add and a restoring shift-subtract step.
    always_comb begin
        sum     = {1'b0, rem_in} + (quo_in[0] ? {1'b0, d} : '0);
        shifted = {rem_in, quo_in[WIDTH-1]};
        fits    = (shifted >= {1'b0, d});
        rem_out = rem_in;
        quo_out = quo_in;
        if (is_div) begin
            // The partial remainder stays below d, so the W-bit difference
            // never loses a significant bit.
            if (fits) begin
                rem_out = shifted[WIDTH-1:0] - d;
                quo_out = {quo_in[WIDTH-2:0], 1'b1};
            end else begin
                rem_out = shifted[WIDTH-1:0];
                quo_out = {quo_in[WIDTH-2:0], 1'b0};
            end
        end else begin
            rem_out = sum[WIDTH:1];
            quo_out = {sum[0], quo_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Optional feature macro: MULDIV_EARLY_OUT_EN -- a mult/div whose op_b is
// zero skips the iteration phase and commits one cycle after acceptance.
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clk_enable,
    input  logic             start,
    input  muldiv_op_t       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int ITER  = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(ITER + 1);

    muldiv_state_t    state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             zero_q, zero_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH-1:0] fix_quot, fix_rem;
    logic [2*WIDTH-1:0] prod_mag, fix_prod;

    logic [WIDTH-1:0] chain_rem [0:BITS_PER_CYCLE];
    logic [WIDTH-1:0] chain_quo [0:BITS_PER_CYCLE];

    // Conditional two's-complement negation of a WIDTH-bit value.
    function automatic logic [WIDTH-1:0] neg_if(input logic c, input logic [WIDTH-1:0] x);
        return c ? -x : x;
    endfunction

    assign chain_rem[0] = rem_q;
    assign chain_quo[0] = quo_q;

    // BITS_PER_CYCLE radix-2 steps cascaded within one CALC cycle.
    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        muldiv_step #(
            .WIDTH (WIDTH)
        ) u_step (
            .is_div  (is_div_q),
            .d       (d_q),
            .rem_in  (chain_rem[g]),
            .quo_in  (chain_quo[g]),
            .rem_out (chain_rem[g+1]),
            .quo_out (chain_quo[g+1])
        );
    end

    // Next-state and datapath selection for the sequencer.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        d_d       = d_q;
        a_d       = a_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        zero_d    = zero_q;

        // Operand magnitudes for an incoming request.
        a_neg = is_signed_op(op) & op_a[WIDTH-1];
        b_neg = is_signed_op(op) & op_b[WIDTH-1];
        abs_a = neg_if(a_neg, op_a);
        abs_b = neg_if(b_neg, op_b);

        // Signed results for the commit cycle.
        prod_mag = {rem_q, quo_q};
        fix_prod = neg_q ? -prod_mag : prod_mag;
        fix_quot = neg_if(neg_q, quo_q);
        fix_rem  = neg_if(rem_neg_q, rem_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op == MTHI) begin
                        hi_d = op_a;
                    end else if (op == MTLO) begin
                        lo_d = op_a;
                    end else if (is_arith_op(op)) begin
                        is_div_d  = is_div_op(op);
                        d_d       = is_div_op(op) ? abs_b : abs_a;
                        quo_d     = is_div_op(op) ? abs_a : abs_b;
                        rem_d     = '0;
                        a_d       = op_a;
                        neg_d     = a_neg ^ b_neg;
                        rem_neg_d = a_neg;
                        zero_d    = (op_b == '0);
                        cnt_d     = '0;
                        busy_d    = 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
                        state_d   = (op_b == '0) ? FIX : CALC;
`else
                        state_d   = CALC;
`endif
                    end
                end
            end
            CALC: begin
                rem_d = chain_rem[BITS_PER_CYCLE];
                quo_d = chain_quo[BITS_PER_CYCLE];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (is_div_q) begin
                    // Divide by zero returns all ones and the raw dividend,
                    // independent of operand signs.
                    if (zero_q) begin
                        lo_d = '1;
                        hi_d = a_q;
                    end else begin
                        lo_d = fix_quot;
                        hi_d = fix_rem;
                    end
                end else begin
                    hi_d = fix_prod[2*WIDTH-1:WIDTH];
                    lo_d = fix_prod[WIDTH-1:0];
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer and datapath registers; clk_enable low freezes everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            d_q       <= '0;
            a_q       <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            zero_q    <= 1'b0;
        end else if (clk_enable) begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            d_q       <= d_d;
            a_q       <= a_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            zero_q    <= zero_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit at radix 2 and radix 16.
module tb_mips_muldiv_unit
    import mips_muldiv_pkg::*;
;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int EXP_DZ = 1;
`else
    localparam int EXP_DZ = 33;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        clk_enable = 1'b1;
    logic        start = 1'b0;
    muldiv_op_t  op = MULTU;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic        start4 = 1'b0;
    muldiv_op_t  op4 = MULTU;
    logic [31:0] a4 = '0;
    logic [31:0] b4 = '0;
    logic        busy4, done4;
    logic [31:0] hi4, lo4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mips_muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .clk_enable(clk_enable), .start(start),
        .op(op), .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    mips_muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .clk_enable(clk_enable), .start(start4),
        .op(op4), .op_a(a4), .op_b(b4), .busy(busy4), .done(done4), .hi(hi4), .lo(lo4)
    );

    // Issue one request on the radix-2 unit and count cycles busy stays high.
    task automatic run_op(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        @(negedge clk);
        start = 1'b1; op = o; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL reset_lo: got %h want 0", lo); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_multu_max;
        int n;
        run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
        n_cmp++; if (n !== 33) begin n_bad++; $display("FAIL multu_busy_cycles: got %0d want 33", n); end
        n_cmp++; if (hi !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        n_cmp++; if (lo !== 32'h00000001) begin n_bad++; $display("FAIL multu_lo: got %h want 00000001", lo); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL multu_done: got %b want 1", done); end
        @(posedge clk); #1;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL multu_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_signed;
        int n;
        run_op(MULT, 32'hFFFFFFFD, 32'd7, n);
        n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mult_neg_hi: got %h want ffffffff", hi); end
        n_cmp++; if (lo !== 32'hFFFFFFEB) begin n_bad++; $display("FAIL mult_neg_lo: got %h want ffffffeb", lo); end
        run_op(DIV, 32'hFFFFFFF9, 32'd2, n);
        n_cmp++; if (lo !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL div_neg_quot: got %h want fffffffd", lo); end
        n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL div_neg_rem: got %h want ffffffff", hi); end
        run_op(DIVU, 32'd100, 32'd7, n);
        n_cmp++; if (lo !== 32'd14) begin n_bad++; $display("FAIL divu_quot: got %h want 0000000e", lo); end
        n_cmp++; if (hi !== 32'd2) begin n_bad++; $display("FAIL divu_rem: got %h want 00000002", hi); end
        run_op(DIV, 32'h80000000, 32'hFFFFFFFF, n);
        n_cmp++; if (lo !== 32'h80000000) begin n_bad++; $display("FAIL div_ovf_quot: got %h want 80000000", lo); end
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL div_ovf_rem: got %h want 0", hi); end
    endtask

    task automatic test_div_zero;
        int n;
        run_op(DIV, 32'd5, 32'd0, n);
        n_cmp++; if (n !== EXP_DZ) begin n_bad++; $display("FAIL div0_busy_cycles: got %0d want %0d", n, EXP_DZ); end
        n_cmp++; if (lo !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL div0_quot: got %h want ffffffff", lo); end
        n_cmp++; if (hi !== 32'd5) begin n_bad++; $display("FAIL div0_rem: got %h want 00000005", hi); end
        run_op(DIV, 32'hFFFFFFFB, 32'd0, n);
        n_cmp++; if (lo !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL div0_neg_quot: got %h want ffffffff", lo); end
        n_cmp++; if (hi !== 32'hFFFFFFFB) begin n_bad++; $display("FAIL div0_neg_rem: got %h want fffffffb", hi); end
        run_op(MULTU, 32'd9, 32'd0, n);
        n_cmp++; if (n !== EXP_DZ) begin n_bad++; $display("FAIL mul0_busy_cycles: got %0d want %0d", n, EXP_DZ); end
        n_cmp++; if ({hi, lo} !== 64'h0) begin n_bad++; $display("FAIL mul0_result: got %h want 0", {hi, lo}); end
    endtask

    task automatic test_move_and_illegal;
        int n;
        run_op(MTHI, 32'h12345678, 32'h0, n);
        n_cmp++; if (hi !== 32'h12345678) begin n_bad++; $display("FAIL mthi: got %h want 12345678", hi); end
        n_cmp++; if (n !== 0 || done !== 1'b0) begin n_bad++; $display("FAIL mthi_no_busy: got busy_cycles=%0d done=%b want 0 0", n, done); end
        run_op(MTLO, 32'hAABBCCDD, 32'h0, n);
        n_cmp++; if (lo !== 32'hAABBCCDD) begin n_bad++; $display("FAIL mtlo: got %h want aabbccdd", lo); end
        n_cmp++; if (hi !== 32'h12345678) begin n_bad++; $display("FAIL mtlo_keeps_hi: got %h want 12345678", hi); end
        run_op(muldiv_op_t'(3'd7), 32'h0, 32'h3, n);
        n_cmp++; if (n !== 0 || busy !== 1'b0) begin n_bad++; $display("FAIL illegal_busy: got busy_cycles=%0d busy=%b want 0 0", n, busy); end
        n_cmp++; if ({hi, lo} !== 64'h12345678_AABBCCDD) begin n_bad++; $display("FAIL illegal_hilo: got %h want 12345678aabbccdd", {hi, lo}); end
    endtask

    task automatic test_back_to_back;
        int n;
        run_op(MULTU, 32'd7, 32'd6, n);
        n_cmp++; if (lo !== 32'd42 || done !== 1'b1) begin n_bad++; $display("FAIL b2b_first: got lo=%h done=%b want 0000002a 1", lo, done); end
        run_op(DIVU, 32'd100, 32'd7, n);
        n_cmp++; if (n !== 33) begin n_bad++; $display("FAIL b2b_busy_cycles: got %0d want 33", n); end
        n_cmp++; if ({hi, lo} !== {32'd2, 32'd14}) begin n_bad++; $display("FAIL b2b_result: got %h want 000000020000000e", {hi, lo}); end
    endtask

    task automatic test_radix4;
        logic [31:0] va [3];
        logic [31:0] vb [3];
        muldiv_op_t  vo [3];
        logic [63:0] vexp [3];
        int n;
        va[0] = 32'd7;        vb[0] = 32'd6;        vo[0] = MULTU; vexp[0] = 64'd42;
        va[1] = 32'hFFFFFFFF; vb[1] = 32'hFFFFFFFF; vo[1] = MULTU; vexp[1] = 64'hFFFFFFFE_00000001;
        va[2] = 32'd100;      vb[2] = 32'd7;        vo[2] = DIVU;  vexp[2] = {32'd2, 32'd14};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start4 = 1'b1; op4 = vo[i]; a4 = va[i]; b4 = vb[i];
            @(posedge clk); #1;
            start4 = 1'b0;
            n = 0;
            while (busy4 && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            n_cmp++; if (n !== 9) begin n_bad++; $display("FAIL r4_busy_cycles[%0d]: got %0d want 9", i, n); end
            n_cmp++; if ({hi4, lo4} !== vexp[i]) begin n_bad++; $display("FAIL r4_result[%0d]: got %h want %h", i, {hi4, lo4}, vexp[i]); end
            n_cmp++; if (done4 !== 1'b1) begin n_bad++; $display("FAIL r4_done[%0d]: got %b want 1", i, done4); end
        end
    endtask

    task automatic test_stall;
        int n;
        run_op(MTHI, 32'h11111111, 32'h0, n);
        run_op(MTLO, 32'h22222222, 32'h0, n);
        @(negedge clk);
        start = 1'b1; op = MULTU; op_a = 32'd3; op_b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        repeat (3) begin @(posedge clk); #1; n++; end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL stall_busy_mid: got %b want 1", busy); end
        start = 1'b1; op = MTLO; op_a = 32'hDEADBEEF;
        @(posedge clk); #1; n++;
        start = 1'b0;
        n_cmp++; if ({hi, lo} !== 64'h11111111_22222222) begin n_bad++; $display("FAIL stall_hold_hilo: got %h want 1111111122222222", {hi, lo}); end
        clk_enable = 1'b0;
        repeat (5) begin @(posedge clk); #1; n++; end
        clk_enable = 1'b1;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        n_cmp++; if (n !== 38) begin n_bad++; $display("FAIL stall_latency: got %0d want 38", n); end
        n_cmp++; if ({hi, lo} !== 64'd15) begin n_bad++; $display("FAIL stall_result: got %h want 000000000000000f", {hi, lo}); end
        clk_enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL stall_done_held: got %b want 1", done); end
        clk_enable = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL stall_done_drop: got %b want 0", done); end
    endtask

    task automatic test_reset_mid;
        int n;
        run_op(MTHI, 32'h5A5A5A5A, 32'h0, n);
        @(negedge clk);
        start = 1'b1; op = DIVU; op_a = 32'd100; op_b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL midreset_ctrl: got busy=%b done=%b want 0 0", busy, done); end
        n_cmp++; if ({hi, lo} !== 64'h0) begin n_bad++; $display("FAIL midreset_hilo: got %h want 0", {hi, lo}); end
        @(negedge clk);
        reset_n = 1'b1;
        run_op(DIVU, 32'd100, 32'd7, n);
        n_cmp++; if (n !== 33 || {hi, lo} !== {32'd2, 32'd14}) begin n_bad++; $display("FAIL postreset_divu: got cycles=%0d hilo=%h want 33 000000020000000e", n, {hi, lo}); end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_signed();
        test_div_zero();
        test_move_and_illegal();
        test_back_to_back();
        test_radix4();
        test_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mips_muldiv_unit.md
# mips_muldiv_unit

- Iterative, parametrised multiply/divide unit that owns the HI/LO architectural registers of the multicycle MIPS core.
- It replaces the combinational mult/div path and the pair of single-register HI/LO instances.
- Operations are started with a start/busy/done handshake. The core stalls on `busy` before any MFHI/MFLO or new mult/div.
- Width and radix (bits retired per cycle) are parameters.

## Interface
- `WIDTH`, default 32: operand width; HI/LO are each `WIDTH` bits. Must be even.
- `BITS_PER_CYCLE`, default 1: multiplier/quotient bits retired per CALC cycle. Legal values are 1, 2, 4, and it must divide `WIDTH`. `ITER = WIDTH/BITS_PER_CYCLE`.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `clk_enable` in 1: global advance enable. When low, all state is frozen.
- `start` in 1: request; sampled on an edge with `clk_enable` high.
- `op` in 3: `muldiv_op_t` = MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- `op_a` in `WIDTH`: rs value (multiplicand/dividend; data for MTHI/MTLO).
- `op_b` in `WIDTH`: rt value (multiplier/divisor).
- `busy` out 1: operation in progress; `start` is ignored while high.
- `done` out 1: one-cycle pulse in the cycle after HI/LO are written by a mult/div.
- `hi` out `WIDTH`: HI register.
- `lo` out `WIDTH`: LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE
  - `start` with MTHI/MTLO writes `op_a` into `hi`/`lo` on that edge. No busy, no done.
  - `start` with MULT/MULTU/DIV/DIVU latches the operands, takes absolute values for signed ops, records the result signs, clears the counter, and goes to CALC.
- CALC
  - Each enabled edge performs `BITS_PER_CYCLE` shift-add (mult) or restoring shift-subtract (div) steps and increments the counter.
  - After `ITER` edges, goes to FIX.
- FIX
  - Applies sign correction: product negated if the operand signs differ; quotient negated if the signs differ; remainder takes the dividend's sign.
  - Writes `hi`/`lo` and returns to IDLE.
  - `done` is registered high for exactly the next cycle.
- Results:
  - mult: `hi:lo` = full 2·`WIDTH` product.
  - div: `lo` = quotient truncated toward zero; `hi` = remainder.
- Divide by zero (`op_b`=0): `lo` = all ones, `hi` = `op_a` (unsigned and signed alike).
- Signed overflow (DIV of −2^(WIDTH−1) by −1): `lo` = −2^(WIDTH−1), `hi` = 0.
- `start` while `busy`: no effect on state, operands or HI/LO.
- `start` in the `done` cycle is accepted (`busy` is already low).
- Illegal `op` encodings are ignored in IDLE.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter 0.
- Reset mid-operation aborts immediately and asynchronously to these values.
- Mult/div accepted at edge E0:
  - `busy`=1 from E0 until edge E0+ITER+1 (FIX edge).
  - `hi`/`lo` change only at E0+ITER+1.
  - `done`=1 during the cycle following that edge.
  - Busy duration: ITER+1 enabled cycles (33 at defaults).
- MTHI/MTLO: result visible in the cycle after the accepting edge.
- `hi`/`lo` hold their old values throughout CALC.
- `clk_enable` low stretches latency cycle-for-cycle. `done` stays asserted until the next enabled edge.

## Configuration
- `MULDIV_EARLY_OUT_EN` defined:
  - An accepted mult/div with `op_b`=0 skips CALC and goes directly to FIX.
  - `busy` lasts 1 cycle; results are as specified above (mult → 0, div → divide-by-zero values).
- Undefined: every mult/div takes the full ITER+1 cycles regardless of operands.

## Structure
- Package `mips_muldiv_pkg` holds:
  - `muldiv_op_t` enum with the encodings MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5.
  - `muldiv_state_t` (IDLE/CALC/FIX).
- One combinational sub-module, `muldiv_step`, performs a single radix-2 mult or div step. It is instantiated `BITS_PER_CYCLE` times in a chain inside the CALC datapath.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001; `busy` high 33 cycles; single `done` pulse.
- MULT −3 × 7 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- DIV −7/2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU 100/7 -> `lo`=14, `hi`=2.
- DIV 5/0 -> `lo`=0xFFFFFFFF, `hi`=5; `busy` 1 cycle with `MULDIV_EARLY_OUT_EN`, 33 cycles without.
- DIV 0x80000000/0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- Repeat MULTU 7×6 at `BITS_PER_CYCLE`=4 -> `lo`=42 after 9 busy cycles.
- MULTU started, `start`+MTLO issued mid-CALC (ignored), `clk_enable` low 5 cycles -> latency 38; `reset_n` low on a later operation's 10th CALC cycle -> `busy`/`done`/`hi`/`lo` = 0 immediately.
